// File: rtl/aes_pkg.sv
// Shared definitions for the AES round-control logic: FSM state type and
// the key-length to round-count mapping.
package aes_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        INIT    = 3'd2,
        ROUND   = 3'd3,
        FINAL   = 3'd4,
        CAPTURE = 3'd5,
        DONE    = 3'd6
    } aes_ctrl_state_t;

    // Round counter / key index width; 14 rounds is the largest case.
    localparam int CNT_W = 4;

    // Number of AES rounds for a given key length in bits.
    function automatic logic [CNT_W-1:0] nr_of(input int k);
        case (k)
            192:     nr_of = 4'd12;
            256:     nr_of = 4'd14;
            default: nr_of = 4'd10;
        endcase
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop level synchronizer for slow control signals crossing from the
// SPI domain into the local clock domain.
module sync_2ff #(
    parameter int DATA_W = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] meta_p0;
    logic [DATA_W-1:0] sync_p1;

    // First flop may go metastable; only the second flop output is consumed.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            meta_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            meta_p0 <= d;
            sync_p1 <= meta_p0;
        end
    end

    assign q = sync_p1;

endmodule

// File: rtl/aes_ctrl.sv
// AES round sequencer: waits for the SPI load strobe to fall, then steps the
// round engine through initial key addition, Nr rounds and result capture.
module aes_ctrl
    import aes_pkg::*;
#(
    parameter int K = 128
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic             dir,
    output logic             init_state,
    output logic             round_en,
    output logic             last_round,
    output logic [CNT_W-1:0] key_idx,
    output logic             dir_q,
    output logic             result_we,
    output logic             done
);

    localparam logic [CNT_W-1:0] NR    = nr_of(K);
    localparam logic [CNT_W-1:0] NR_M1 = NR - 4'd1;

    aes_ctrl_state_t  state;
    aes_ctrl_state_t  state_d;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_d;
    logic             dir_d;
    logic             load_s;

    sync_2ff #(
        .DATA_W (1)
    ) u_load_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (load),
        .q       (load_s)
    );

    // State, round counter and latched direction registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
            dir_q <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            dir_q <= dir_d;
        end
    end

    // Next-state, counter update and per-state strobes; a new load during
    // any active phase abandons the operation without writing a result.
    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        dir_d      = dir_q;
        init_state = 1'b0;
        round_en   = 1'b0;
        last_round = 1'b0;
        result_we  = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (load_s) state_d = LOAD;
            end
            LOAD: begin
                dir_d = dir;
                cnt_d = '0;
                if (!load_s) state_d = INIT;
            end
            INIT: begin
                init_state = 1'b1;
                cnt_d      = 4'd1;
                state_d    = load_s ? LOAD : ROUND;
            end
            ROUND: begin
                round_en = 1'b1;
                if (cnt != NR) cnt_d = cnt + 4'd1;
                if (load_s)
                    state_d = LOAD;
                else if (cnt == NR_M1)
                    state_d = FINAL;
            end
            FINAL: begin
                round_en   = 1'b1;
                last_round = 1'b1;
                state_d    = load_s ? LOAD : CAPTURE;
            end
            CAPTURE: begin
                result_we = !load_s;
                state_d   = load_s ? LOAD : DONE;
            end
            DONE: begin
                done = !load_s;
                if (load_s) state_d = LOAD;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Decryption walks the key schedule backwards.
    assign key_idx = dir_q ? (NR - cnt) : cnt;

endmodule

// File: tb/tb_aes_ctrl.sv
// Scoreboard bench: three controllers (K=128/192/256) share one stimulus
// stream; expected strobe events are queued per instance when an operation
// is launched and popped by a monitor whenever a controller strobes.
module tb_aes_ctrl;

    localparam int NINST    = 3;
    localparam int EV_INIT  = 0;
    localparam int EV_ROUND = 1;
    localparam int EV_WE    = 2;
    localparam int EV_DONE  = 3;

    typedef struct {
        int kind;
        int key;
        int last;
        int off;
        int dir;
    } ev_t;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             load;
    logic             dir;
    logic [NINST-1:0] init_v;
    logic [NINST-1:0] round_v;
    logic [NINST-1:0] last_v;
    logic [NINST-1:0] we_v;
    logic [NINST-1:0] done_v;
    logic [NINST-1:0] dirq_v;
    logic [3:0]       key_v [NINST];

    int checks   = 0;
    int failures = 0;

    ev_t q0[$];
    ev_t q1[$];
    ev_t q2[$];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NINST; gi++) begin : g_inst
        aes_ctrl #(
            .K (128 + 64 * gi)
        ) u_dut (
            .clk        (clk),
            .reset_n    (reset_n),
            .load       (load),
            .dir        (dir),
            .init_state (init_v[gi]),
            .round_en   (round_v[gi]),
            .last_round (last_v[gi]),
            .key_idx    (key_v[gi]),
            .dir_q      (dirq_v[gi]),
            .result_we  (we_v[gi]),
            .done       (done_v[gi])
        );
    end

    function automatic int nr_for_k(input int k);
        if (k == 128) return 10;
        if (k == 192) return 12;
        return 14;
    endfunction

    function automatic int b2i(input logic b);
        return b ? 1 : 0;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic push_ev(input int i, input ev_t e);
        case (i)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic pop_ev(input int i, output ev_t e, output int ok);
        ok = 0;
        e  = '{default: 0};
        case (i)
            0:       if (q0.size() > 0) begin e = q0.pop_front(); ok = 1; end
            1:       if (q1.size() > 0) begin e = q1.pop_front(); ok = 1; end
            default: if (q2.size() > 0) begin e = q2.pop_front(); ok = 1; end
        endcase
    endtask

    function automatic int q_size(input int i);
        case (i)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    // Reference model: cycle offset t counts from the INIT cycle (t=1).
    // cut limits the visible offsets; supp drops a write/done strobe that
    // falls exactly on the cut cycle (the operation is being abandoned).
    task automatic announce(input int d, input int cut, input int supp);
        for (int i = 0; i < NINST; i++) begin
            int nr;
            nr = nr_for_k(128 + 64 * i);
            for (int t = 1; t <= nr + 3; t++) begin
                ev_t e;
                if (cut != 0 && t > cut) break;
                e.off  = t;
                e.dir  = d;
                e.last = 0;
                e.key  = 0;
                if (t == 1) begin
                    e.kind = EV_INIT;
                    e.key  = (d != 0) ? nr : 0;
                end else if (t <= nr + 1) begin
                    e.kind = EV_ROUND;
                    e.key  = (d != 0) ? nr - (t - 1) : t - 1;
                    e.last = (t - 1 == nr) ? 1 : 0;
                end else if (t == nr + 2) begin
                    e.kind = EV_WE;
                end else begin
                    e.kind = EV_DONE;
                end
                if (!(supp != 0 && t == cut && (e.kind == EV_WE || e.kind == EV_DONE)))
                    push_ev(i, e);
            end
        end
    endtask

    task automatic monitor();
        int off [NINST];
        int prev_done [NINST];
        for (int i = 0; i < NINST; i++) begin
            off[i]       = 0;
            prev_done[i] = 0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < NINST; i++) begin
                int  kind;
                int  ok;
                ev_t e;
                int  a_key;
                int  a_last;
                int  a_dir;
                int  nstrobe;
                if (init_v[i]) off[i] = 1;
                else if (off[i] != 0 && off[i] < 1000) off[i]++;
                nstrobe = b2i(init_v[i]) + b2i(round_v[i]) + b2i(we_v[i]) + b2i(done_v[i]);
                checks++;
                if (nstrobe > 1 || (last_v[i] && !round_v[i])) begin
                    failures++;
                    $display("FAIL exclusive inst%0d: init=%0d round=%0d last=%0d we=%0d done=%0d, required at most one strobe",
                             i, init_v[i], round_v[i], last_v[i], we_v[i], done_v[i]);
                end
                kind = -1;
                if (init_v[i]) kind = EV_INIT;
                else if (round_v[i]) kind = EV_ROUND;
                else if (we_v[i]) kind = EV_WE;
                else if (done_v[i] && prev_done[i] == 0) kind = EV_DONE;
                prev_done[i] = b2i(done_v[i]);
                if (kind >= 0) begin
                    pop_ev(i, e, ok);
                    a_key  = int'(key_v[i]);
                    a_last = b2i(last_v[i]);
                    a_dir  = b2i(dirq_v[i]);
                    checks++;
                    if (ok == 0) begin
                        failures++;
                        $display("FAIL unexpected inst%0d: kind=%0d off=%0d key=%0d, required no strobe",
                                 i, kind, off[i], a_key);
                    end else if (e.kind != kind || (kind <= EV_ROUND && e.key != a_key) ||
                                 e.last != a_last || e.off != off[i] || e.dir != a_dir) begin
                        failures++;
                        $display("FAIL event inst%0d: kind=%0d key=%0d last=%0d off=%0d dir=%0d, required kind=%0d key=%0d last=%0d off=%0d dir=%0d",
                                 i, kind, a_key, a_last, off[i], a_dir, e.kind, e.key, e.last, e.off, e.dir);
                    end
                end
            end
        end
    endtask

    task automatic start_op(input int d, input int hold, input int cut, input int supp);
        dir  = (d != 0);
        load = 1'b1;
        repeat (hold) @(negedge clk);
        load = 1'b0;
        announce(d, cut, supp);
        repeat (3) @(negedge clk);
        chk("init_latency", int'(init_v), 7);
    endtask

    task automatic drain(input string tag);
        @(negedge clk);
        for (int i = 0; i < NINST; i++) chk({tag, "_drain"}, q_size(i), 0);
    endtask

    task automatic wait_done(input string tag);
        int c = 0;
        while (done_v != 3'b111 && c < 40) begin
            @(negedge clk);
            c++;
        end
        chk({tag, "_done"}, int'(done_v), 7);
        drain(tag);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_strobes"}, int'({init_v, round_v, last_v, we_v, done_v, dirq_v}), 0);
        for (int i = 0; i < NINST; i++) chk({tag, "_key"}, int'(key_v[i]), 0);
    endtask

    task automatic abort_op(input int d, input int hold, input int a);
        start_op(d, hold, a + 2, 1);
        repeat (a - 1) @(negedge clk);
        load = 1'b1;
        repeat (6) @(negedge clk);
        chk("abort_no_done", int'(done_v), 0);
        drain("abort");
        start_op(d, hold, 0, 0);
        wait_done("after_abort");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d;
        reset_n = 1'b0;
        load    = 1'b0;
        dir     = 1'b0;
        fork
            monitor();
        join_none

        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        chk_all_zero("idle");

        // Long encrypt load, then full operation on every key size.
        start_op(0, 300, 0, 0);
        wait_done("enc_long");

        // Decrypt: key schedule walked backwards.
        start_op(1, 8, 0, 0);
        wait_done("dec");

        // Abort during round 5.
        abort_op(0, 6, 6);

        // Abort landing on the K=128 capture cycle.
        abort_op(1, 3, 10);

        // Sit in DONE, then reload with a direction change during LOAD.
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            chk("done_held", int'(done_v), 7);
        end
        dir  = 1'b0;
        load = 1'b1;
        @(negedge clk);
        chk("done_pre_sync", int'(done_v), 7);
        @(negedge clk);
        chk("done_release", int'(done_v), 0);
        @(negedge clk);
        dir = 1'b1;
        @(negedge clk);
        chk("dir_follow", int'(dirq_v), 7);
        start_op(1, 4, 0, 0);
        wait_done("reload");

        // Reset pulse during the K=128 final round.
        start_op(1, 5, 11, 0);
        repeat (10) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        chk_all_zero("mid_reset");
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        chk_all_zero("post_reset_idle");
        drain("mid_reset");
        start_op(0, 7, 0, 0);
        wait_done("post_reset");

        // Single-cycle load glitch.
        start_op(1, 1, 0, 0);
        wait_done("glitch");

        // Randomized mix of full and abandoned operations.
        for (int n = 0; n < 14; n++) begin
            d = int'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0) begin
                abort_op(d, int'($urandom_range(1, 20)), int'($urandom_range(1, 10)));
            end else begin
                start_op(d, int'($urandom_range(1, 20)), 0, 0);
                wait_done("random");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
